// File: rtl/fix_frame_detector.sv
// FIX byte-stream framer: finds "8=" headers and "<SOH>10=" trailers, forwards message bytes
// with start/end strobes and decodes the 3-digit ASCII checksum field that follows the trailer.
module fix_frame_detector #(
  parameter int MAX_BODY_LEN = 1024,
  parameter int LEN_W        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       start_o,
  output logic       end_o,
  output logic       in_frame_o,
  output logic [7:0] rx_cksum_o,
  output logic       rx_cksum_vld_o,
  output logic       frame_err_o,
  output logic [1:0] dbg_state_o
);

  localparam logic [7:0] SOH    = 8'h01;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_8  = 8'h38;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_EQ = 8'h3D;

  typedef enum logic [1:0] {S_HUNT, S_HDR, S_BODY, S_CKSUM} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [23:0]      r_hist;      // {oldest, middle, newest} accepted bytes
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_digits;
  logic [9:0]       r_val;

  logic [7:0]       r_data;
  logic             r_dv;
  logic             r_start;
  logic             r_end;
  logic             r_in_frame;
  logic [7:0]       r_cksum;
  logic             r_cksum_vld;
  logic             r_err;

  logic             w_is_digit;
  logic             w_trailer;
  logic             w_len_full;
  logic             w_hdr_start;
  logic [9:0]       w_val_mac;
  logic             w_start;
  logic             w_end;
  logic             w_fwd;
  logic             w_err;
  logic             w_ck_ok;
  logic             w_acc;

  // valid_i qualifies byte_i for one cycle; there is no ready, the stream is never stalled.
  assign w_is_digit  = (byte_i >= ASC_0) && (byte_i <= ASC_9);
  assign w_trailer   = (byte_i == ASC_EQ) && (r_hist == {SOH, ASC_1, ASC_0});
  assign w_len_full  = (r_len == LEN_W'(MAX_BODY_LEN));
  assign w_hdr_start = (byte_i == ASC_8) && (r_hist[7:0] == SOH);
  assign w_val_mac   = (r_val * 10'd10) + {6'd0, byte_i[3:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid_i) begin
      case (r_state)
        S_HUNT:  if (w_hdr_start) w_state_nxt = S_HDR;
        S_HDR: begin
          if (byte_i == ASC_EQ)  w_state_nxt = S_BODY;
          else if (w_hdr_start)  w_state_nxt = S_HDR;
          else                   w_state_nxt = S_HUNT;
        end
        S_BODY: begin
          if (w_trailer)         w_state_nxt = S_CKSUM;
          else if (w_len_full)   w_state_nxt = S_HUNT;
        end
        S_CKSUM: begin
          if (!(w_is_digit && (r_digits != 2'd3))) w_state_nxt = S_HUNT;
        end
        default:                 w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_comb begin
    w_start = 1'b0;
    w_end   = 1'b0;
    w_fwd   = 1'b0;
    w_err   = 1'b0;
    w_ck_ok = 1'b0;
    w_acc   = 1'b0;
    if (valid_i) begin
      case (r_state)
        S_HDR: begin
          w_start = (byte_i == ASC_EQ);
          w_fwd   = (byte_i == ASC_EQ);
        end
        S_BODY: begin
          // The trailer wins over the length limit so a body of exactly MAX_BODY_LEN bytes closes.
          if (w_trailer) begin
            w_end = 1'b1;
            w_fwd = 1'b1;
          end else if (w_len_full) begin
            w_err = 1'b1;
          end else begin
            w_fwd = 1'b1;
          end
        end
        S_CKSUM: begin
          if (w_is_digit && (r_digits != 2'd3))
            w_acc = 1'b1;
          else if ((byte_i == SOH) && (r_digits == 2'd3) && (r_val <= 10'd255))
            w_ck_ok = 1'b1;
          else
            w_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist      <= {SOH, SOH, SOH};
      r_len       <= '0;
      r_digits    <= '0;
      r_val       <= '0;
      r_data      <= '0;
      r_dv        <= 1'b0;
      r_start     <= 1'b0;
      r_end       <= 1'b0;
      r_in_frame  <= 1'b0;
      r_cksum     <= '0;
      r_cksum_vld <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_dv        <= w_fwd;
      r_start     <= w_start;
      r_end       <= w_end;
      r_cksum_vld <= w_ck_ok;
      r_err       <= w_err;
      if (valid_i) begin
        r_data <= byte_i;
        r_hist <= {r_hist[15:0], byte_i};
      end
      if (w_start)    r_len <= '0;
      else if (w_fwd) r_len <= r_len + 1'b1;
      if (w_end) begin
        r_digits <= '0;
        r_val    <= '0;
      end else if (w_acc) begin
        r_digits <= r_digits + 1'b1;
        r_val    <= w_val_mac;
      end
      if (w_ck_ok) r_cksum <= r_val[7:0];
      if (w_start)               r_in_frame <= 1'b1;
      else if (w_ck_ok || w_err) r_in_frame <= 1'b0;
    end
  end

  assign data_o         = r_data;
  assign data_valid_o   = r_dv;
  assign start_o        = r_start;
  assign end_o          = r_end;
  assign in_frame_o     = r_in_frame;
  assign rx_cksum_o     = r_cksum;
  assign rx_cksum_vld_o = r_cksum_vld;
  assign frame_err_o    = r_err;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_fix_frame_detector.sv
// Directed bench for fix_frame_detector: a full-size instance plus one with MAX_BODY_LEN=8,
// both fed the same byte stream.
module tb_fix_frame_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_i;
  logic       valid_i;

  logic [7:0] data_o, rx_cksum_o;
  logic       data_valid_o, start_o, end_o, in_frame_o, rx_cksum_vld_o, frame_err_o;
  logic [1:0] dbg_state_o;

  logic [7:0] s_data_o, s_rx_cksum_o;
  logic       s_data_valid_o, s_start_o, s_end_o, s_in_frame_o, s_rx_cksum_vld_o, s_frame_err_o;
  logic [1:0] s_dbg_state_o;

  always #5 clk = ~clk;

  fix_frame_detector dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .valid_i(valid_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .start_o(start_o), .end_o(end_o),
    .in_frame_o(in_frame_o), .rx_cksum_o(rx_cksum_o), .rx_cksum_vld_o(rx_cksum_vld_o),
    .frame_err_o(frame_err_o), .dbg_state_o(dbg_state_o)
  );

  fix_frame_detector #(.MAX_BODY_LEN(8), .LEN_W(4)) dut_s (
    .clk(clk), .rst(rst), .byte_i(byte_i), .valid_i(valid_i),
    .data_o(s_data_o), .data_valid_o(s_data_valid_o), .start_o(s_start_o), .end_o(s_end_o),
    .in_frame_o(s_in_frame_o), .rx_cksum_o(s_rx_cksum_o), .rx_cksum_vld_o(s_rx_cksum_vld_o),
    .frame_err_o(s_frame_err_o), .dbg_state_o(s_dbg_state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  int n_start, n_end, n_vld, n_err, fwd_bad, gap_bad, start_at, end_at, err_at, cur_idx;
  int s_err, s_err_at, s_fwd, s_vld;
  logic [7:0] last_ck, s_ck, prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_start = 0; n_end = 0; n_vld = 0; n_err = 0; fwd_bad = 0; gap_bad = 0;
    start_at = -1; end_at = -1; err_at = -1;
    s_err = 0; s_err_at = -1; s_fwd = 0; s_vld = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [7:0] b, input logic v);
    logic [7:0] e;
    prev_data = data_o;
    byte_i  = b;
    valid_i = v;
    @(posedge clk);
    #1;
    if (!v && (data_valid_o || start_o || end_o || rx_cksum_vld_o || frame_err_o ||
               data_o !== prev_data)) gap_bad++;
    if (start_o) begin n_start++; start_at = cur_idx; if (data_o !== 8'h3D) fwd_bad++; end
    if (end_o)   begin n_end++;   end_at = cur_idx;   if (data_o !== 8'h3D) fwd_bad++; end
    if (start_o && end_o) fwd_bad++;
    if (rx_cksum_vld_o) begin n_vld++; last_ck = rx_cksum_o; end
    if (frame_err_o) begin n_err++; err_at = cur_idx; end
    if (data_valid_o) begin
      if (exp_q.size() == 0) fwd_bad++;
      else begin
        e = exp_q.pop_front();
        if (data_o !== e) fwd_bad++;
      end
    end
    if (s_frame_err_o) begin s_err++; s_err_at = cur_idx; end
    if (s_data_valid_o) s_fwd++;
    if (s_rx_cksum_vld_o) begin s_vld++; s_ck = s_rx_cksum_o; end
  endtask

  function automatic logic [7:0] to_byte(input string s, input int i);
    logic [7:0] b;
    b = s[i];
    if (b == 8'h7C) b = 8'h01;
    return b;
  endfunction

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(to_byte(s, i));
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      cur_idx = i;
      step(to_byte(s, i), 1'b1);
      if (gaps) step(8'h38, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; byte_i = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    cur_idx = 0; last_ck = 8'h00; s_ck = 8'h00;
    clr();
    do_reset();
    check("rst_data", 32'(data_o), 0);
    check("rst_dv", 32'(data_valid_o), 0);
    check("rst_inframe", 32'(in_frame_o), 0);
    check("rst_cksum", 32'(rx_cksum_o), 0);
    check("rst_state", 32'(dbg_state_o), 0);

    // Basic message, valid every cycle
    clr();
    push_exp("=FIX.4.2|9=5|35=0|10=");
    send_str("8=FIX.4.2|9=5|35=0|10=161|", 1'b0);
    check("t1_starts", 32'(n_start), 1);
    check("t1_start_at", 32'(start_at), 1);
    check("t1_ends", 32'(n_end), 1);
    check("t1_end_at", 32'(end_at), 21);
    check("t1_vld", 32'(n_vld), 1);
    check("t1_cksum", 32'(last_ck), 161);
    check("t1_err", 32'(n_err), 0);
    check("t1_fwd", 32'(fwd_bad), 0);
    check("t1_fwd_left", 32'(exp_q.size()), 0);
    check("t1_inframe", 32'(in_frame_o), 0);

    // Same message with a gap after every byte
    clr();
    push_exp("=FIX.4.2|9=5|35=0|10=");
    send_str("8=FIX.4.2|9=5|35=0|10=161|", 1'b1);
    check("t2_starts", 32'(n_start), 1);
    check("t2_ends", 32'(n_end), 1);
    check("t2_vld", 32'(n_vld), 1);
    check("t2_cksum", 32'(last_ck), 161);
    check("t2_err", 32'(n_err), 0);
    check("t2_fwd", 32'(fwd_bad), 0);
    check("t2_fwd_left", 32'(exp_q.size()), 0);
    check("t2_gaps", 32'(gap_bad), 0);

    // Checksum field decoding
    clr();
    push_exp("=A|10=");
    send_str("8=A|10=007|", 1'b0);
    check("t3_007_vld", 32'(n_vld), 1);
    check("t3_007_val", 32'(rx_cksum_o), 7);
    check("t3_007_err", 32'(n_err), 0);
    clr();
    push_exp("=A|10=");
    send_str("8=A|10=256|", 1'b0);
    check("t3_256_vld", 32'(n_vld), 0);
    check("t3_256_err", 32'(n_err), 1);
    check("t3_256_at", 32'(err_at), 10);
    check("t3_256_hold", 32'(rx_cksum_o), 7);
    check("t3_256_inframe", 32'(in_frame_o), 0);
    clr();
    push_exp("=A|10=");
    send_str("8=A|10=12|", 1'b0);
    check("t3_12_err", 32'(n_err), 1);
    check("t3_12_at", 32'(err_at), 9);
    check("t3_12_vld", 32'(n_vld), 0);
    clr();
    push_exp("=A|10=");
    send_str("8=A|10=1a3|", 1'b0);
    check("t3_1a3_err", 32'(n_err), 1);
    check("t3_1a3_at", 32'(err_at), 8);
    check("t3_1a3_vld", 32'(n_vld), 0);
    check("t3_fwd", 32'(fwd_bad), 0);

    // Body length limit on the MAX_BODY_LEN=8 instance
    do_reset();
    clr();
    send_str("8=ABCDEFGHI", 1'b0);
    check("t4_err", 32'(s_err), 1);
    check("t4_err_at", 32'(s_err_at), 10);
    check("t4_fwd_cnt", 32'(s_fwd), 9);
    check("t4_inframe", 32'(s_in_frame_o), 0);
    clr();
    send_str("|8=ABCDE|10=050|", 1'b0);
    check("t4_exact_err", 32'(s_err), 0);
    check("t4_exact_vld", 32'(s_vld), 1);
    check("t4_exact_ck", 32'(s_ck), 50);
    do_reset();
    check("t4_rst_cksum", 32'(rx_cksum_o), 0);

    // Header only recognised after SOH
    clr();
    push_exp("=Z|10=");
    send_str("x8=abc|8=Z|10=100|", 1'b0);
    check("t5_starts", 32'(n_start), 1);
    check("t5_start_at", 32'(start_at), 8);
    check("t5_cksum", 32'(last_ck), 100);
    check("t5_fwd", 32'(fwd_bad), 0);

    // Reset mid-body, then recovery
    clr();
    push_exp("=ABC");
    send_str("8=ABC", 1'b0);
    check("t6_inframe_mid", 32'(in_frame_o), 1);
    rst = 1'b1; byte_i = 8'h41; valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_dv", 32'(data_valid_o), 0);
    check("t6_rst_data", 32'(data_o), 0);
    check("t6_rst_inframe", 32'(in_frame_o), 0);
    check("t6_rst_cksum", 32'(rx_cksum_o), 0);
    check("t6_rst_state", 32'(dbg_state_o), 0);
    rst = 1'b0;
    clr();
    push_exp("=AB|10=");
    send_str("8=AB|10=042|", 1'b0);
    check("t6_vld", 32'(n_vld), 1);
    check("t6_cksum", 32'(rx_cksum_o), 42);

    // Back-to-back frames with no idle bytes
    clr();
    push_exp("=AB|10=");
    push_exp("=C|10=");
    send_str("8=AB|10=042|8=C|10=099|", 1'b0);
    check("b2b_starts", 32'(n_start), 2);
    check("b2b_ends", 32'(n_end), 2);
    check("b2b_vld", 32'(n_vld), 2);
    check("b2b_cksum", 32'(last_ck), 99);
    check("b2b_fwd", 32'(fwd_bad), 0);
    check("b2b_fwd_left", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
